// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment patterns, scan FSM state type and digit count shared by the scan decoder
package seg_pkg;

   localparam int DIGIT_NUM = 4;
   localparam logic [3:0] BCD_INVALID = 4'hF;

   // Active-low patterns, leftmost bit is segment a, rightmost is segment g
   localparam logic [0:6] SEG_0 = 7'b0000001;
   localparam logic [0:6] SEG_1 = 7'b1001111;
   localparam logic [0:6] SEG_2 = 7'b0010010;
   localparam logic [0:6] SEG_3 = 7'b0000110;
   localparam logic [0:6] SEG_4 = 7'b1001100;
   localparam logic [0:6] SEG_5 = 7'b0100100;
   localparam logic [0:6] SEG_6 = 7'b0100000;
   localparam logic [0:6] SEG_7 = 7'b0001111;
   localparam logic [0:6] SEG_8 = 7'b0000000;
   localparam logic [0:6] SEG_9 = 7'b0000100;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HOLD
   } scan_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - active-low seven-segment pattern to BCD nibble with invalid flag
module seg7_to_bcd
   import seg_pkg::*;
(
   input  logic [0:6] seg,
   output logic [3:0] bcd,
   output logic       invalid
);

   always_comb begin
      invalid = 1'b0;
      bcd     = BCD_INVALID;
      case (seg)
         SEG_0:   bcd = 4'd0;
         SEG_1:   bcd = 4'd1;
         SEG_2:   bcd = 4'd2;
         SEG_3:   bcd = 4'd3;
         SEG_4:   bcd = 4'd4;
         SEG_5:   bcd = 4'd5;
         SEG_6:   bcd = 4'd6;
         SEG_7:   bcd = 4'd7;
         SEG_8:   bcd = 4'd8;
         SEG_9:   bcd = 4'd9;
         default: invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers BCD digits, points and value from a multiplexed 7-seg scan
// SEG_SCAN_BIN_EN builds the BCD-to-binary value output; otherwise value is tied to 0.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [0:6]  segments,
   input  logic [3:0]  enabler,
   input  logic        dot,
   output logic [15:0] digits,
   output logic [3:0]  dots,
   output logic [13:0] value,
   output logic        frame_valid,
   output logic        frame_error,
   output logic        stale
);

   localparam int CNT_W  = $clog2(SETTLE_CYCLES);
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_FIRE  = CNT_W'(SETTLE_CYCLES - 2);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

   logic [0:6]        seg_q, seg_d, seg_prev_q, seg_prev_d;
   logic [3:0]        en_q, en_d, en_prev_q, en_prev_d;
   logic              dot_q, dot_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   scan_state_t       state_q, state_d;
   logic [15:0]       shadow_q, shadow_d;
   logic [3:0]        sdots_q, sdots_d;
   logic [3:0]        seen_q, seen_d;
   logic              err_q, err_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [15:0]       digits_q, digits_d;
   logic [3:0]        dots_q, dots_d;
   logic              frame_valid_q, frame_valid_d;
   logic              frame_error_q, frame_error_d;
   logic              stale_q, stale_d;

   logic       sel_valid, changed, capture, complete, timeout;
   logic [1:0] sel_idx;
   logic [3:0] dec_bcd;
   logic       dec_bad;

   seg7_to_bcd u_dec (
      .seg     (seg_q),
      .bcd     (dec_bcd),
      .invalid (dec_bad)
   );

   always_comb begin
      seg_d      = segments;
      en_d       = enabler;
      dot_d      = dot;
      seg_prev_d = seg_q;
      en_prev_d  = en_q;

      sel_valid = $onehot(~en_q);
      changed   = (seg_q != seg_prev_q) || (en_q != en_prev_q);
      sel_idx   = 2'd0;
      for (int k = 0; k < DIGIT_NUM; k++)
         if (!en_q[k]) sel_idx = 2'(k);

      cnt_d = changed ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);

      // Capture fires on the edge where the count would reach SETTLE_CYCLES-1
      capture = 1'b0;
      state_d = state_q;
      case (state_q)
         IDLE:    if (sel_valid) state_d = SETTLE;
         SETTLE: begin
            if (!sel_valid) state_d = IDLE;
            else if (!changed && cnt_q == CNT_FIRE) begin
               capture = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (!sel_valid)  state_d = IDLE;
            else if (changed) state_d = SETTLE;
         end
         default: state_d = IDLE;
      endcase

      complete = (seen_q == 4'hF);
      timeout  = !capture && (idle_q == IDLE_LAST);
      idle_d   = capture ? '0 : ((idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1);

      shadow_d = shadow_q;
      sdots_d  = sdots_q;
      seen_d   = seen_q;
      err_d    = err_q;
      if (complete || timeout) begin
         seen_d = '0;
         err_d  = 1'b0;
      end
      // A capture in the completion cycle belongs to the next frame
      if (capture) begin
         shadow_d[{sel_idx, 2'b00} +: 4] = dec_bcd;
         sdots_d[sel_idx] = ~dot_q;
         seen_d[sel_idx]  = 1'b1;
         if (dec_bad) err_d = 1'b1;
      end

      digits_d      = complete ? shadow_q : digits_q;
      dots_d        = complete ? sdots_q  : dots_q;
      frame_valid_d = complete;
      frame_error_d = complete && err_q;
      stale_d       = stale_q;
      if (timeout)  stale_d = 1'b1;
      if (complete) stale_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_q         <= '1;
         en_q          <= '1;
         dot_q         <= 1'b1;
         seg_prev_q    <= '1;
         en_prev_q     <= '1;
         cnt_q         <= '0;
         state_q       <= IDLE;
         shadow_q      <= '0;
         sdots_q       <= '0;
         seen_q        <= '0;
         err_q         <= 1'b0;
         idle_q        <= '0;
         digits_q      <= '0;
         dots_q        <= '0;
         frame_valid_q <= 1'b0;
         frame_error_q <= 1'b0;
         stale_q       <= 1'b0;
      end else begin
         seg_q         <= seg_d;
         en_q          <= en_d;
         dot_q         <= dot_d;
         seg_prev_q    <= seg_prev_d;
         en_prev_q     <= en_prev_d;
         cnt_q         <= cnt_d;
         state_q       <= state_d;
         shadow_q      <= shadow_d;
         sdots_q       <= sdots_d;
         seen_q        <= seen_d;
         err_q         <= err_d;
         idle_q        <= idle_d;
         digits_q      <= digits_d;
         dots_q        <= dots_d;
         frame_valid_q <= frame_valid_d;
         frame_error_q <= frame_error_d;
         stale_q       <= stale_d;
      end
   end

   assign digits      = digits_q;
   assign dots        = dots_q;
   assign frame_valid = frame_valid_q;
   assign frame_error = frame_error_q;
   assign stale       = stale_q;

`ifdef SEG_SCAN_BIN_EN
   logic [13:0] value_q, value_d;

   // Undecodable digits hold 4'hF in the shadow and contribute nothing
   function automatic logic [13:0] bcd_to_bin(input logic [15:0] d);
      logic [13:0] acc;
      logic [3:0]  nib;
      acc = '0;
      for (int k = DIGIT_NUM - 1; k >= 0; k--) begin
         nib = d[4*k +: 4];
         acc = acc * 14'd10 + ((nib > 4'd9) ? 14'd0 : {10'd0, nib});
      end
      return acc;
   endfunction

   always_comb value_d = complete ? bcd_to_bin(shadow_q) : value_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) value_q <= '0;
      else      value_q <= value_d;
   end

   assign value = value_q;
`else
   assign value = '0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed scans checked against a run-length model of the display scan
module tb_seg_scan_decoder;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 100;
`ifdef SEG_SCAN_BIN_EN
   localparam bit BIN_EN = 1'b1;
`else
   localparam bit BIN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [0:6]  seg_in;
   logic [3:0]  en_in;
   logic        dot_in;
   logic [15:0] digits;
   logic [3:0]  dots;
   logic [13:0] value;
   logic        frame_valid, frame_error, stale;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .segments    (seg_in),
      .enabler     (en_in),
      .dot         (dot_in),
      .digits      (digits),
      .dots        (dots),
      .value       (value),
      .frame_valid (frame_valid),
      .frame_error (frame_error),
      .stale       (stale)
   );

   logic [6:0] pat_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a digit is taken once its anode+segment sample has repeated SETTLE times
   logic [3:0]  m_en_last;
   logic [6:0]  m_seg_last, s_seg;
   int          m_run, m_idle;
   logic        m_pend, m_pdot, m_pbad, m_complete, m_timeout;
   logic [1:0]  m_pidx;
   logic [3:0]  m_pnib;
   logic [3:0]  m_shadow [4];
   logic [3:0]  m_sdots, m_seen;
   logic        m_err;
   int          m_sum;
   logic [15:0] exp_digits;
   logic [3:0]  exp_dots;
   logic [13:0] exp_value;
   logic        exp_fv, exp_fe, exp_stale;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_en_last = 4'hF; m_seg_last = 7'h7F; m_run = 0; m_idle = 0;
         m_pend = 0; m_pdot = 0; m_pbad = 0; m_pidx = 0; m_pnib = 0;
         for (int i = 0; i < 4; i++) m_shadow[i] = 4'h0;
         m_sdots = 0; m_seen = 0; m_err = 0;
         exp_digits = 0; exp_dots = 0; exp_value = 0; exp_fv = 0; exp_fe = 0; exp_stale = 0;
      end else begin
         m_complete = (m_seen == 4'hF);
         m_timeout  = !m_pend && (m_idle == TIMEOUT - 1);
         exp_fv = m_complete;
         exp_fe = m_complete && m_err;
         if (m_complete) begin
            exp_digits = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
            exp_dots   = m_sdots;
            m_sum = 0;
            for (int i = 3; i >= 0; i--) m_sum = m_sum * 10 + ((m_shadow[i] <= 9) ? int'(m_shadow[i]) : 0);
            exp_value = BIN_EN ? 14'(m_sum) : 14'd0;
         end
         if (m_pend) m_idle = 0;
         else if (m_idle < TIMEOUT) m_idle++;
         if (m_complete || m_timeout) begin m_seen = 0; m_err = 0; end
         if (m_pend) begin
            m_shadow[m_pidx] = m_pnib;
            m_sdots[m_pidx]  = m_pdot;
            m_seen[m_pidx]   = 1'b1;
            m_err = m_err | m_pbad;
         end
         if (m_timeout)  exp_stale = 1'b1;
         if (m_complete) exp_stale = 1'b0;

         s_seg = seg_in;
         if (en_in == m_en_last && s_seg == m_seg_last) begin
            if (m_run < 1000) m_run++;
         end else m_run = 1;
         m_en_last = en_in; m_seg_last = s_seg;
         m_pend = (m_run == SETTLE) && ($countones(~en_in) == 1);
         for (int k = 0; k < 4; k++) if (!en_in[k]) m_pidx = 2'(k);
         m_pdot = ~dot_in;
         m_pnib = 4'hF; m_pbad = 1'b1;
         for (int d = 0; d < 10; d++) if (pat_tab[d] == s_seg) begin m_pnib = 4'(d); m_pbad = 1'b0; end
      end
   end

   int          fv_count = 0;
   logic [15:0] lat_digits = 0;
   logic [3:0]  lat_dots = 0;
   logic [13:0] lat_value = 0;
   logic        lat_fe = 0;

   always @(negedge clk) begin
      if (rst) begin
         chk("digits",      32'(digits),      32'(exp_digits));
         chk("dots",        32'(dots),        32'(exp_dots));
         chk("value",       32'(value),       32'(exp_value));
         chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
         chk("frame_error", 32'(frame_error), 32'(exp_fe));
         chk("stale",       32'(stale),       32'(exp_stale));
         if (frame_valid) begin
            fv_count++;
            lat_digits = digits; lat_dots = dots; lat_value = value; lat_fe = frame_error;
         end
      end
   end

   task automatic drive(input logic [3:0] en, input logic [6:0] pat, input bit dp, input int n);
      en_in = en; seg_in = pat; dot_in = ~dp;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic show(input int idx, input int val, input bit dp, input int n);
      drive(~(4'b0001 << idx), pat_tab[val], dp, n);
   endtask

   task automatic blank(input int n);
      drive(4'hF, 7'h7F, 1'b0, n);
   endtask

   task automatic expect_frames(input string tag, input int base, input int n);
      chk({tag, " frame count"}, 32'(fv_count - base), 32'(n));
   endtask

   task automatic expect_frame(input string tag, input logic [15:0] d, input logic [3:0] dp,
                               input int v, input bit fe);
      chk({tag, " digits"}, 32'(lat_digits), 32'(d));
      chk({tag, " dots"},   32'(lat_dots),   32'(dp));
      chk({tag, " value"},  32'(lat_value),  BIN_EN ? 32'(v) : 32'd0);
      chk({tag, " error"},  32'(lat_fe),     32'(fe));
   endtask

   initial begin
      int base;
      rst = 1'b0; en_in = 4'hF; seg_in = 7'h7F; dot_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      chk("reset digits", 32'(digits), 32'd0);
      chk("reset value",  32'(value),  32'd0);
      chk("reset fv",     32'(frame_valid), 32'd0);
      chk("reset stale",  32'(stale),  32'd0);

      base = fv_count;
      show(3, 1, 0, 8); show(2, 2, 1, 8); show(1, 3, 0, 8); show(0, 4, 0, 8); blank(4);
      expect_frames("scan1234", base, 1);
      expect_frame("scan1234", 16'h1234, 4'b0100, 1234, 1'b0);

      base = fv_count;
      show(3, 5, 0, 8); show(2, 6, 0, 8); show(1, 7, 0, 3); show(0, 8, 0, 8); blank(4);
      expect_frames("short dwell", base, 0);
      show(1, 7, 0, 4); blank(4);
      expect_frames("long dwell", base, 1);
      expect_frame("long dwell", 16'h5678, 4'b0000, 5678, 1'b0);

      base = fv_count;
      show(3, 9, 0, 8); show(2, 0, 0, 8); show(1, 1, 0, 8); drive(4'b1110, 7'b1111110, 1'b0, 8); blank(4);
      expect_frames("bad pattern", base, 1);
      expect_frame("bad pattern", 16'h901F, 4'b0000, 9010, 1'b1);

      base = fv_count;
      show(3, 2, 0, 8); drive(4'b0011, pat_tab[0], 1'b0, 6); show(2, 0, 0, 8);
      blank(6); show(1, 4, 0, 8); show(0, 9, 0, 8); blank(4);
      expect_frames("invalid select", base, 1);
      expect_frame("invalid select", 16'h2049, 4'b0000, 2049, 1'b0);

      base = fv_count;
      show(3, 7, 0, 8); show(2, 7, 0, 8); blank(110);
      chk("timeout stale", 32'(stale), 32'd1);
      chk("timeout digits kept", 32'(digits), 32'h2049);
      show(1, 1, 0, 8); show(0, 0, 0, 8); blank(4);
      expect_frames("after timeout partial", base, 0);
      show(3, 4, 0, 8); show(2, 3, 0, 8); blank(4);
      expect_frames("after timeout full", base, 1);
      expect_frame("after timeout", 16'h4310, 4'b0000, 4310, 1'b0);
      chk("stale cleared", 32'(stale), 32'd0);

      base = fv_count;
      show(3, 9, 0, 8); show(2, 9, 0, 8); show(1, 9, 0, 8); blank(2);
      rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      chk("mid reset digits", 32'(digits), 32'd0);
      chk("mid reset dots",   32'(dots),   32'd0);
      chk("mid reset value",  32'(value),  32'd0);
      show(0, 5, 0, 8); blank(4);
      expect_frames("after reset one digit", base, 0);
      show(3, 1, 0, 8); show(2, 0, 0, 8); show(1, 0, 0, 8); blank(4);
      expect_frames("after reset full", base, 1);
      expect_frame("after reset", 16'h1005, 4'b0000, 1005, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
